sonic_vc_demultiplexer: RTL and testbench

Consumes the channel-tagged Avalon-ST packet stream produced by the virtual-channel multiplexer and steers each packet to one of two per-channel output streams.
- Routing channel is locked at start-of-packet and held until end-of-packet.
- Each output has a one-entry registered pipeline stage.
- Beats arriving outside a packet are dropped and counted.
- Sits between the VC mux output and the per-channel egress logic.

---
 rtl/sonic_vc_pkg.sv | 28 ++
 rtl/sonic_vc_demux_stage.sv | 46 ++++
 rtl/sonic_vc_demultiplexer.sv | 128 ++++++++++++
 tb/tb_sonic_vc_demultiplexer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_vc_pkg.sv
// rtl/sonic_vc_pkg.sv - shared widths, FSM states and payload layout for the VC demultiplexer
//
// Purpose : common definitions imported by the demultiplexer top and its output stage.
// Contents: default DATA_W / EMPTY_W, the IDLE/PKT state enum, the packed beat payload
//           struct and its width.

package sonic_vc_pkg;

    localparam int DATA_W_DEF  = 128;
    localparam int EMPTY_W_DEF = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } vc_state_t;

    // Field order matches the concatenation used to build stage payloads in the top.
    typedef struct packed {
        logic [DATA_W_DEF-1:0]  data;
        logic [EMPTY_W_DEF-1:0] empty;
        logic                   eop;
        logic                   error;
        logic                   sop;
    } vc_payload_t;

    localparam int PAYLOAD_W_DEF = $bits(vc_payload_t);

endpackage

// File: rtl/sonic_vc_demux_stage.sv
// rtl/sonic_vc_demux_stage.sv - one-entry registered output stage
//
// Purpose : holds a single beat for one output channel; payload is stable while the
//           beat waits for downstream ready.
// Ports   : clk, reset_n (async, active-low)
//           load_i        - accepted beat targeted at this stage
//           payload_i     - packed beat fields
//           ready_i       - downstream ready
//           valid_o       - beat held in the stage
//           payload_o     - held beat fields
//           stage_ready_o - stage can take a beat this cycle

module sonic_vc_demux_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] payload_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] payload_o,
    output logic         stage_ready_o
);

    logic         valid_q;
    logic [W-1:0] payload_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (load_i) begin
            valid_q   <= 1'b1;
            payload_q <= payload_i;
        end else if (ready_i) begin
            valid_q   <= 1'b0;
        end
    end

    // Empty, or the held beat leaves this cycle.
    assign stage_ready_o = ready_i || !valid_q;
    assign valid_o       = valid_q;
    assign payload_o     = payload_q;

endmodule

// File: rtl/sonic_vc_demultiplexer.sv
// rtl/sonic_vc_demultiplexer.sv - steers channel-tagged packets to two per-channel outputs
//
// Purpose : the routing channel is taken from in_channel on SOP and locked until EOP.
//           Beats outside a packet are dropped and counted (saturating). An SOP inside an
//           open packet is forwarded to the locked channel with error forced high.
// Ports   : clk, reset_n (async, active-low)
//           in_*            - input Avalon-ST beat (channel, valid/ready, data, error,
//                             sop/eop, empty)
//           out0_*, out1_*  - per-channel Avalon-ST outputs, 1-cycle latency
//           drop_count      - saturating count of dropped orphan beats

module sonic_vc_demultiplexer
    import sonic_vc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int EMPTY_W = EMPTY_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_channel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_error,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic               out0_valid,
    input  logic               out0_ready,
    output logic [DATA_W-1:0]  out0_data,
    output logic               out0_error,
    output logic               out0_startofpacket,
    output logic               out0_endofpacket,
    output logic [EMPTY_W-1:0] out0_empty,
    output logic               out1_valid,
    input  logic               out1_ready,
    output logic [DATA_W-1:0]  out1_data,
    output logic               out1_error,
    output logic               out1_startofpacket,
    output logic               out1_endofpacket,
    output logic [EMPTY_W-1:0] out1_empty,
    output logic [CNT_W-1:0]   drop_count
);

    // {data, empty, eop, error, sop} - same layout as vc_payload_t.
    localparam int PW = DATA_W + EMPTY_W + 3;

    vc_state_t        state_q;
    logic             lock_q;
    logic [CNT_W-1:0] drop_q;

    logic          orphan;
    logic          target;
    logic [1:0]    stage_ready;
    logic          accept;
    logic          bad_sop;
    logic [PW-1:0] beat_payload;
    logic [PW-1:0] out0_payload;
    logic [PW-1:0] out1_payload;

    assign orphan  = (state_q == ST_IDLE) && !in_startofpacket;
    assign bad_sop = (state_q == ST_PKT) && in_startofpacket;
    assign target  = (state_q == ST_PKT) ? lock_q : in_channel;

    // Only the target stage gates the input; the other output cannot stall or free it.
    assign in_ready = orphan ? 1'b1 : stage_ready[target];
    assign accept   = in_valid && in_ready;

    assign beat_payload = {in_data, in_empty, in_endofpacket,
                           in_error | bad_sop, in_startofpacket};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            lock_q  <= 1'b0;
            drop_q  <= '0;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (orphan) begin
                        if (drop_q != {CNT_W{1'b1}}) begin
                            drop_q <= drop_q + 1'b1;
                        end
                    end else if (!in_endofpacket) begin
                        state_q <= ST_PKT;
                        lock_q  <= in_channel;
                    end
                end
                ST_PKT: begin
                    // A bad SOP leaves state and lock untouched unless it also closes the packet.
                    if (in_endofpacket) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign drop_count = drop_q;

    sonic_vc_demux_stage #(.W(PW)) u_stage0 (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_i        (accept && !orphan && (target == 1'b0)),
        .payload_i     (beat_payload),
        .ready_i       (out0_ready),
        .valid_o       (out0_valid),
        .payload_o     (out0_payload),
        .stage_ready_o (stage_ready[0])
    );

    sonic_vc_demux_stage #(.W(PW)) u_stage1 (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_i        (accept && !orphan && (target == 1'b1)),
        .payload_i     (beat_payload),
        .ready_i       (out1_ready),
        .valid_o       (out1_valid),
        .payload_o     (out1_payload),
        .stage_ready_o (stage_ready[1])
    );

    assign {out0_data, out0_empty, out0_endofpacket, out0_error, out0_startofpacket} = out0_payload;
    assign {out1_data, out1_empty, out1_endofpacket, out1_error, out1_startofpacket} = out1_payload;

endmodule

// File: tb/tb_sonic_vc_demultiplexer.sv
// tb/tb_sonic_vc_demultiplexer.sv - directed self-checking bench for sonic_vc_demultiplexer

module tb_sonic_vc_demultiplexer;

    localparam int DATA_W  = 128;
    localparam int EMPTY_W = 2;
    localparam int CNT_W   = 16;

    logic               clk;
    logic               reset_n;
    logic               in_channel;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic               in_error;
    logic               in_startofpacket;
    logic               in_endofpacket;
    logic [EMPTY_W-1:0] in_empty;
    logic               out0_valid, out1_valid;
    logic               out0_ready, out1_ready;
    logic [DATA_W-1:0]  out0_data, out1_data;
    logic               out0_error, out1_error;
    logic               out0_startofpacket, out1_startofpacket;
    logic               out0_endofpacket, out1_endofpacket;
    logic [EMPTY_W-1:0] out0_empty, out1_empty;
    logic [CNT_W-1:0]   drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    sonic_vc_demultiplexer #(
        .DATA_W (DATA_W),
        .EMPTY_W(EMPTY_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_channel        (in_channel),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_error          (in_error),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out0_valid        (out0_valid),
        .out0_ready        (out0_ready),
        .out0_data         (out0_data),
        .out0_error        (out0_error),
        .out0_startofpacket(out0_startofpacket),
        .out0_endofpacket  (out0_endofpacket),
        .out0_empty        (out0_empty),
        .out1_valid        (out1_valid),
        .out1_ready        (out1_ready),
        .out1_data         (out1_data),
        .out1_error        (out1_error),
        .out1_startofpacket(out1_startofpacket),
        .out1_endofpacket  (out1_endofpacket),
        .out1_empty        (out1_empty),
        .drop_count        (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input logic ch, input logic sop, input logic eop,
                            input logic [DATA_W-1:0] data, input logic [EMPTY_W-1:0] empty,
                            input logic err);
        in_valid         = 1'b1;
        in_channel       = ch;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_data          = data;
        in_empty         = empty;
        in_error         = err;
    endtask

    task automatic idle_in();
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_data          = '0;
        in_empty         = '0;
        in_error         = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic [DATA_W-1:0] pat_a5;

    initial begin
        pat_a5     = {16{8'hA5}};
        reset_n    = 1'b0;
        in_channel = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        idle_in();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        sample();
        check("rst_out0_valid", out0_valid, 0);
        check("rst_out1_valid", out1_valid, 0);
        check("rst_out0_data", out0_data, 0);
        check("rst_out1_empty", out1_empty, 0);
        check("rst_drop", drop_count, 0);
        step();

        // 1: channel-0 three-beat packet
        set_beat(0, 1, 0, 128'h11, 0, 0);
        sample();
        check("t1_rdy_b1", in_ready, 1);
        check("t1_o0v_pre", out0_valid, 0);
        step();
        set_beat(0, 0, 0, 128'h22, 0, 0);
        sample();
        check("t1_rdy_b2", in_ready, 1);
        check("t1_o0v_b1", out0_valid, 1);
        check("t1_o0d_b1", out0_data, 128'h11);
        check("t1_o0sop_b1", out0_startofpacket, 1);
        check("t1_o1v_b1", out1_valid, 0);
        step();
        set_beat(0, 0, 1, 128'h33, 2, 0);
        sample();
        check("t1_rdy_b3", in_ready, 1);
        check("t1_o0d_b2", out0_data, 128'h22);
        check("t1_o0sop_b2", out0_startofpacket, 0);
        check("t1_o1v_b2", out1_valid, 0);
        step();
        idle_in();
        sample();
        check("t1_o0d_b3", out0_data, 128'h33);
        check("t1_o0eop_b3", out0_endofpacket, 1);
        check("t1_o0emp_b3", out0_empty, 2);
        check("t1_o1v_b3", out1_valid, 0);
        step();
        sample();
        check("t1_o0v_done", out0_valid, 0);
        step();

        // 2: single-beat on ch1, back-to-back ch0 packet
        set_beat(1, 1, 1, pat_a5, 1, 0);
        sample();
        check("t2_rdy_a", in_ready, 1);
        step();
        set_beat(0, 1, 0, 128'h44, 0, 0);
        sample();
        check("t2_rdy_b", in_ready, 1);
        check("t2_o1v", out1_valid, 1);
        check("t2_o1d", out1_data, pat_a5);
        check("t2_o1sop", out1_startofpacket, 1);
        check("t2_o1eop", out1_endofpacket, 1);
        check("t2_o1emp", out1_empty, 1);
        check("t2_o0v_a", out0_valid, 0);
        step();
        set_beat(0, 0, 1, 128'h55, 0, 0);
        sample();
        check("t2_o0d_b", out0_data, 128'h44);
        check("t2_o1v_b", out1_valid, 0);
        step();
        idle_in();
        sample();
        check("t2_o0d_c", out0_data, 128'h55);
        check("t2_o0eop_c", out0_endofpacket, 1);
        step();

        // 3: in_channel changes mid-packet, lock holds ch1
        set_beat(1, 1, 0, 128'h61, 0, 0);
        sample();
        step();
        set_beat(0, 0, 0, 128'h62, 0, 0);
        sample();
        check("t3_o1d_1", out1_data, 128'h61);
        check("t3_rdy_2", in_ready, 1);
        step();
        set_beat(0, 0, 1, 128'h63, 0, 0);
        sample();
        check("t3_o1v_2", out1_valid, 1);
        check("t3_o1d_2", out1_data, 128'h62);
        check("t3_o0v_2", out0_valid, 0);
        step();
        idle_in();
        sample();
        check("t3_o1d_3", out1_data, 128'h63);
        check("t3_o1eop_3", out1_endofpacket, 1);
        check("t3_o0v_3", out0_valid, 0);
        step();

        // 4: backpressure on out0, out1_ready toggles
        set_beat(0, 1, 0, 128'h71, 0, 0);
        sample();
        step();
        out0_ready = 1'b0;
        set_beat(0, 0, 0, 128'h72, 0, 0);
        for (int i = 0; i < 4; i++) begin
            out1_ready = i[0];
            sample();
            check("t4_rdy_stall", in_ready, 0);
            check("t4_o0v_stall", out0_valid, 1);
            check("t4_o0d_stall", out0_data, 128'h71);
            step();
        end
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        sample();
        check("t4_rdy_rel", in_ready, 1);
        check("t4_o0d_rel", out0_data, 128'h71);
        step();
        set_beat(0, 0, 1, 128'h73, 0, 0);
        sample();
        check("t4_o0d_72", out0_data, 128'h72);
        check("t4_o0v_72", out0_valid, 1);
        step();
        idle_in();
        sample();
        check("t4_o0d_73", out0_data, 128'h73);
        check("t4_o0eop_73", out0_endofpacket, 1);
        check("t4_o1v", out1_valid, 0);
        step();
        sample();
        check("t4_o0v_done", out0_valid, 0);
        step();

        // 5: orphan beats and counter saturation
        set_beat(0, 0, 0, 128'h91, 0, 0);
        sample();
        check("t5_rdy_orph", in_ready, 1);
        step();
        sample();
        check("t5_drop_1", drop_count, 1);
        check("t5_rdy_orph2", in_ready, 1);
        step();
        idle_in();
        sample();
        check("t5_drop_2", drop_count, 2);
        check("t5_o0v", out0_valid, 0);
        check("t5_o1v", out1_valid, 0);
        step();
        set_beat(1, 0, 1, 128'h92, 0, 0);
        repeat (65533) @(posedge clk);
        #1 idle_in();
        sample();
        check("t5_drop_full", drop_count, 16'hFFFF);
        check("t5_o1v_full", out1_valid, 0);
        step();
        set_beat(0, 0, 0, 128'h93, 0, 0);
        sample();
        check("t5_rdy_sat", in_ready, 1);
        step();
        idle_in();
        sample();
        check("t5_drop_sat", drop_count, 16'hFFFF);
        step();

        // 6: bad SOP mid-packet, then asynchronous reset
        set_beat(0, 1, 0, 128'h81, 0, 0);
        sample();
        step();
        set_beat(1, 1, 0, 128'h82, 0, 0);
        sample();
        check("t6_rdy_bad", in_ready, 1);
        check("t6_o0d_81", out0_data, 128'h81);
        check("t6_o0err_81", out0_error, 0);
        step();
        idle_in();
        sample();
        check("t6_o0v_82", out0_valid, 1);
        check("t6_o0d_82", out0_data, 128'h82);
        check("t6_o0err_82", out0_error, 1);
        check("t6_o0sop_82", out0_startofpacket, 1);
        check("t6_o1v_82", out1_valid, 0);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_o0v", out0_valid, 0);
        check("t6_rst_o0d", out0_data, 0);
        check("t6_rst_drop", drop_count, 0);
        step();
        reset_n = 1'b1;
        // Orphan beat only counts if the FSM came back in IDLE
        set_beat(0, 0, 0, 128'hB1, 0, 0);
        sample();
        check("t6_rdy_post", in_ready, 1);
        step();
        idle_in();
        sample();
        check("t6_drop_post", drop_count, 1);
        check("t6_o0v_post", out0_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
